// File: rtl/mem_bus_stage.sv
// mem_bus_stage: memory-access pipeline stage bridging EX results to a single-outstanding data bus and the write-back stage.
// Optional feature: define MB_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_bus_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_flush,
    input  logic [31:0] ex_mb__alu_y,
    input  logic [31:0] ex_mb__rs2_rdata,
    input  logic [4:0]  ex_mb__rd_addr,
    input  logic        ex_mb__rd_wen,
    input  logic [1:0]  ex_mb__mem_op,
    input  logic [2:0]  ex_mb__mem_width,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        mb_stall,
    output logic [31:0] mb_wb__rd_wdata,
    output logic [4:0]  mb_wb__rd_addr,
    output logic        mb_wb__rd_wen,
    output logic        mb_misalign
);
    typedef enum logic {IDLE, BUS} state_t;
    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d, flush_q, flush_d, wen_q, wen_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_q, wb_d;
    logic [3:0]  strb_q, strb_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  a;
    logic [2:0]  w;
    logic        is_mem, is_st, mis, mis_d;
    logic [31:0] sh, ld_data;
    logic [15:0] half;
    logic [7:0]  byt;
    assign a      = ex_mb__alu_y[1:0];
    assign w      = ex_mb__mem_width;
    assign is_st  = ex_mb__mem_op == 2'b10;
    assign is_mem = is_st || ex_mb__mem_op == 2'b01;
`ifdef MB_MISALIGN_TRAP_EN
    assign mis = w[1] ? |a : (w[0] & a[0]);
`else
    assign mis = 1'b0;
`endif
    // Load lane extraction; the completing transaction is a load whenever the registered write qualifier is clear
    assign sh      = bus_rdata >> {a, 3'b000};
    assign byt     = sh[7:0];
    assign half    = a[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    assign ld_data = w[1] ? bus_rdata : w[0] ? {{16{~w[2] & half[15]}}, half} : {{24{~w[2] & byt[7]}}, byt};
    // Next-state, bus request and write-back selection
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        flush_d  = flush_q;
        wb_d     = wb_q;
        rd_d     = rd_q;
        wen_d    = 1'b0;
        mis_d    = 1'b0;
        mb_stall = 1'b0;
        if (state_q == IDLE) begin
            if (is_mem && !pipe_flush && !mis) begin
                state_d  = BUS;
                mb_stall = 1'b1;
                req_d    = 1'b1;
                we_d     = is_st;
                addr_d   = {ex_mb__alu_y[31:2], 2'b00};
                wdata_d  = w[1] ? ex_mb__rs2_rdata : w[0] ? {2{ex_mb__rs2_rdata[15:0]}} : {4{ex_mb__rs2_rdata[7:0]}};
                strb_d   = w[1] ? 4'b1111 : w[0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
                flush_d  = 1'b0;
            end else begin
                wb_d  = ex_mb__alu_y;
                rd_d  = ex_mb__rd_addr;
                wen_d = ex_mb__rd_wen && !pipe_flush && !(is_mem && mis);
                mis_d = is_mem && !pipe_flush && mis;
            end
        end else begin
            flush_d  = flush_q | pipe_flush;
            mb_stall = !bus_ack;
            if (bus_ack) begin
                state_d = IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
                wb_d    = we_q ? ex_mb__alu_y : ld_data;
                rd_d    = ex_mb__rd_addr;
                wen_d   = !we_q && ex_mb__rd_wen && !flush_q && !pipe_flush;
            end
        end
    end
    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            flush_q <= 1'b0;
            wb_q    <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            flush_q <= flush_d;
            wb_q    <= wb_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
        end
    end
`ifdef MB_MISALIGN_TRAP_EN
    logic mis_q;
    // One-cycle misalignment pulse
    always_ff @(posedge clk) begin
        if (rst) mis_q <= 1'b0;
        else mis_q <= mis_d;
    end
    assign mb_misalign = mis_q;
`else
    assign mb_misalign = 1'b0;
`endif
    assign bus_req         = req_q;
    assign bus_we          = we_q;
    assign bus_addr        = addr_q;
    assign bus_wdata       = wdata_q;
    assign bus_wstrb       = strb_q;
    assign mb_wb__rd_wdata = wb_q;
    assign mb_wb__rd_addr  = rd_q;
    assign mb_wb__rd_wen   = wen_q;
endmodule

// File: tb/tb_mem_bus_stage.sv
// tb_mem_bus_stage: table-driven scoreboard bench for mem_bus_stage (MB_MISALIGN_TRAP_EN selects trap expectations).
module tb_mem_bus_stage;
    logic        clk = 0, rst = 1, pipe_flush = 0, rd_wen = 0, bus_ack = 0;
    logic [31:0] alu_y = 32'hA5A5_0003, rs2 = 32'h1111_2222, bus_rdata = 0;
    logic [4:0]  rd_addr = 5'd17;
    logic [1:0]  mem_op = 2'b01;
    logic [2:0]  mem_width = 3'b010;
    logic        bus_req, bus_we, mb_stall, wb_wen, mb_misalign;
    logic [31:0] bus_addr, bus_wdata, wb_wdata;
    logic [3:0]  bus_wstrb;
    logic [4:0]  wb_addr;
    int checks = 0, errors = 0;

    typedef struct {
        logic [1:0] op; logic [2:0] w; logic [31:0] a, r2, rdata; logic [4:0] rd; logic wen, fl_idle, fl_bus; int dly;
        logic [31:0] e_addr; logic e_we; logic [3:0] e_strb; logic [31:0] e_wdata, e_wb; logic e_wen;
    } vec_t;
    typedef struct { logic [31:0] wdata; logic [4:0] addr; logic wen; } wb_t;
    wb_t sb[$];
    vec_t v[12];

    mem_bus_stage dut (
        .clk(clk), .rst(rst), .pipe_flush(pipe_flush),
        .ex_mb__alu_y(alu_y), .ex_mb__rs2_rdata(rs2), .ex_mb__rd_addr(rd_addr), .ex_mb__rd_wen(rd_wen),
        .ex_mb__mem_op(mem_op), .ex_mb__mem_width(mem_width),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .mb_stall(mb_stall),
        .mb_wb__rd_wdata(wb_wdata), .mb_wb__rd_addr(wb_addr), .mb_wb__rd_wen(wb_wen), .mb_misalign(mb_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input string n);
        wb_t e;
        int stalls = 0;
        bit mem = (t.op == 2'b01 || t.op == 2'b10) && !t.fl_idle;
        mem_op = t.op; mem_width = t.w; alu_y = t.a; rs2 = t.r2; rd_addr = t.rd; rd_wen = t.wen; pipe_flush = t.fl_idle;
        e.wdata = t.e_wb; e.addr = t.rd; e.wen = t.e_wen;
        sb.push_back(e);
        #1 if (mb_stall) stalls++;
        if (mem) begin
            @(negedge clk);
            pipe_flush = 0;
            chk({n, " bus_req"}, bus_req, 1);
            chk({n, " bus_addr"}, bus_addr, t.e_addr);
            chk({n, " bus_we"}, bus_we, t.e_we);
            if (t.e_we) begin
                chk({n, " bus_wstrb"}, bus_wstrb, t.e_strb);
                chk({n, " bus_wdata"}, bus_wdata, t.e_wdata);
            end
            chk({n, " bubble"}, wb_wen, 0);
            for (int i = 0; i < t.dly; i++) begin
                if (i == 0) pipe_flush = t.fl_bus;
                #1 if (mb_stall) stalls++;
                @(negedge clk);
                pipe_flush = 0;
                chk({n, " req_held"}, bus_req, 1);
                chk({n, " addr_held"}, bus_addr, t.e_addr);
                chk({n, " wait_bubble"}, wb_wen, 0);
            end
            bus_ack = 1; bus_rdata = t.rdata;
            #1 chk({n, " ack_stall"}, mb_stall, 0);
        end
        chk({n, " stall_cycles"}, stalls, mem ? 1 + t.dly : 0);
        @(negedge clk);
        bus_ack = 0; pipe_flush = 0; mem_op = 0; rd_wen = 0;
        e = sb.pop_front();
        chk({n, " req_done"}, bus_req, 0);
        chk({n, " rd_wen"}, wb_wen, e.wen);
        if (e.wen) begin
            chk({n, " rd_wdata"}, wb_wdata, e.wdata);
            chk({n, " rd_addr"}, wb_addr, e.addr);
        end
    endtask

    initial begin
        vec_t m;
        //          op     w       a             r2            rdata         rd  wen fi fb dly e_addr        we  strb     e_wdata       e_wb          e_wen
        v[0]  = '{2'b00, 3'b010, 32'h1234,     32'h0,        32'h0,        5, 1, 0, 0, 0, 32'h0,     0, 4'b0000, 32'h0,        32'h1234,     1};
        v[1]  = '{2'b01, 3'b000, 32'h103,      32'h0,        32'h80FFFFFF, 7, 1, 0, 0, 3, 32'h100,   0, 4'b0000, 32'h0,        32'hFFFFFF80, 1};
        v[2]  = '{2'b10, 3'b001, 32'h202,      32'h0000BEEF, 32'h0,        8, 1, 0, 0, 0, 32'h200,   1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0};
        v[3]  = '{2'b01, 3'b010, 32'h40,       32'h0,        32'hDEADBEEF, 9, 1, 0, 1, 2, 32'h40,    0, 4'b0000, 32'h0,        32'h0,        0};
        v[4]  = '{2'b01, 3'b101, 32'h12,       32'h0,        32'h80017FFF, 10, 1, 0, 0, 1, 32'h10,   0, 4'b0000, 32'h0,        32'h00008001, 1};
        v[5]  = '{2'b01, 3'b001, 32'h10,       32'h0,        32'h1234F00D, 11, 1, 0, 0, 0, 32'h10,   0, 4'b0000, 32'h0,        32'hFFFFF00D, 1};
        v[6]  = '{2'b01, 3'b100, 32'h21,       32'h0,        32'h0000A500, 12, 1, 0, 0, 1, 32'h20,   0, 4'b0000, 32'h0,        32'h000000A5, 1};
        v[7]  = '{2'b10, 3'b000, 32'h301,      32'h123456C3, 32'h0,        13, 0, 0, 0, 2, 32'h300,  1, 4'b0010, 32'hC3C3C3C3, 32'h0,        0};
        v[8]  = '{2'b10, 3'b010, 32'h400,      32'hCAFEF00D, 32'h0,        14, 1, 0, 0, 0, 32'h400,  1, 4'b1111, 32'hCAFEF00D, 32'h0,        0};
        v[9]  = '{2'b00, 3'b010, 32'h55,       32'h0,        32'h0,        3, 1, 1, 0, 0, 32'h0,     0, 4'b0000, 32'h0,        32'h55,       0};
        v[10] = '{2'b01, 3'b010, 32'h66,       32'h0,        32'h0,        4, 1, 1, 0, 0, 32'h0,     0, 4'b0000, 32'h0,        32'h66,       0};
        v[11] = '{2'b11, 3'b010, 32'h77,       32'h0,        32'h0,        9, 1, 0, 0, 0, 32'h0,     0, 4'b0000, 32'h0,        32'h77,       1};
        repeat (2) @(negedge clk);
        chk("rst bus_req", bus_req, 0);
        chk("rst bus_we", bus_we, 0);
        chk("rst bus_addr", bus_addr, 0);
        chk("rst bus_wdata", bus_wdata, 0);
        chk("rst bus_wstrb", bus_wstrb, 0);
        chk("rst rd_wen", wb_wen, 0);
        chk("rst rd_wdata", wb_wdata, 0);
        chk("rst rd_addr", wb_addr, 0);
        chk("rst misalign", mb_misalign, 0);
        rst = 0; mem_op = 0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) run(v[i], $sformatf("vec%0d", i));
        // reset in the middle of a bus transaction, then a late ack
        mem_op = 2'b01; mem_width = 3'b010; alu_y = 32'h80; rd_addr = 6; rd_wen = 1;
        @(negedge clk);
        chk("mid bus_req", bus_req, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid_rst bus_req", bus_req, 0);
        chk("mid_rst bus_addr", bus_addr, 0);
        chk("mid_rst rd_wen", wb_wen, 0);
        mem_op = 0; rd_wen = 0; bus_ack = 1; bus_rdata = 32'h12345678;
        #1 chk("late_ack stall", mb_stall, 0);
        @(negedge clk);
        bus_ack = 0;
        chk("late_ack rd_wen", wb_wen, 0);
        chk("late_ack bus_req", bus_req, 0);
`ifdef MB_MISALIGN_TRAP_EN
        mem_op = 2'b01; mem_width = 3'b010; alu_y = 32'h06; rd_addr = 4; rd_wen = 1;
        #1 chk("mis stall", mb_stall, 0);
        @(negedge clk);
        mem_op = 0; rd_wen = 0;
        chk("mis bus_req", bus_req, 0);
        chk("mis flag", mb_misalign, 1);
        chk("mis rd_wen", wb_wen, 0);
        @(negedge clk);
        chk("mis pulse_end", mb_misalign, 0);
        chk("mis no_req", bus_req, 0);
`else
        m = '{2'b01, 3'b010, 32'h06, 32'h0, 32'h11223344, 4, 1, 0, 0, 1, 32'h04, 0, 4'b0000, 32'h0, 32'h11223344, 1};
        run(m, "misword");
        chk("misword flag", mb_misalign, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/mem_bus_stage.md
MEM_BUS_STAGE -- requirements
Module: mem_bus_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pipe_flush  in  1  kill the instruction currently presented on ex_mb__ inputs.
REQ-005 ex_mb__alu_y  in  32  ALU result; byte address for memory ops.
REQ-006 ex_mb__rs2_rdata  in  32  store data (already forwarded upstream).
REQ-007 ex_mb__rd_addr  in  5  destination register.
REQ-008 ex_mb__rd_wen  in  1  destination write enable.
REQ-009 ex_mb__mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
REQ-010 ex_mb__mem_width  in  3  [1:0] 00 byte, 01 half, 10 word; [2] 1 = zero-extend load.
REQ-011 bus_req / bus_we  out  1 / 1  request, write qualifier; registered.
REQ-012 bus_addr / bus_wdata / bus_wstrb  out  32 / 32 / 4  word-aligned address, lane data, byte strobes; registered.
REQ-013 bus_ack / bus_rdata  in  1 / 32  completion, word read data valid with ack.
REQ-014 mb_stall  out  1  combinational; upstream holds ex_mb__ inputs while high.
REQ-015 mb_wb__rd_wdata / mb_wb__rd_addr / mb_wb__rd_wen  out  32 / 5 / 1  registered write-back.
REQ-016 mb_misalign  out  1  registered misalignment flag (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE and BUS.
REQ-018 IDLE, op none or pipe_flush: mb_wb__ SHALL capture alu_y/rd_addr/rd_wen (rd_wen forced 0 on flush) next edge; mb_stall=0; latency 1.
REQ-019 IDLE, load/store, no flush: mb_stall=1, write-back bubble (rd_wen=0), next edge -> BUS with bus_req=1 and bus_addr={alu_y[31:2],2'b00}, bus_we=(store).
REQ-020 Strobes: byte 4'b0001<<alu_y[1:0]; half 4'b0011 (alu_y[1]=0) or 4'b1100; word 4'b1111; bus_wdata byte replicated x4, half x2.
REQ-021 BUS, bus_ack=0: bus_req/addr/wdata/wstrb/we SHALL hold stable; mb_stall=1; write-back bubble.
REQ-022 BUS, bus_ack=1: mb_stall=0 same cycle; next edge -> IDLE, bus_req=0, mb_wb__ written.
REQ-023 Load write-back: lane selected by alu_y[1:0] (byte) or alu_y[1] (half), sign- or zero-extended per mem_width[2]; rd_wen=ex_mb__rd_wen.
REQ-024 Store write-back: rd_wen SHALL be 0.
REQ-025 pipe_flush during BUS SHALL NOT abort the transaction; completion write-back SHALL have rd_wen=0.
REQ-026 Minimum load/store latency SHALL be 2 cycles (ack in first BUS cycle); no back-to-back reissue of the same op.

Reset
REQ-027 rst SHALL force IDLE, bus_req=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, mb_wb__rd_wen=0, mb_wb__rd_wdata=0, mb_wb__rd_addr=0, mb_misalign=0 on the next edge, including mid-transaction; a late bus_ack after reset SHALL be ignored.

Configuration
REQ-028 With MB_MISALIGN_TRAP_EN defined: half with alu_y[0]=1 or word with alu_y[1:0]!=0 SHALL issue no request, no stall, rd_wen=0, mb_misalign=1 for one cycle.
REQ-029 Without MB_MISALIGN_TRAP_EN: mb_misalign SHALL be tied 0; misaligned ops issue normally using REQ-020/023 lane rules.

Verification
REQ-030 op none, alu_y=0x1234, rd=5, wen=1 -> next cycle rd_wdata=0x1234, rd_addr=5, rd_wen=1, no bus_req.
REQ-031 load byte signed, alu_y=0x103, bus_rdata=0x80FFFFFF, ack after 3 BUS cycles -> bus_addr=0x100, stall 4 cycles, rd_wdata=0xFFFFFF80.
REQ-032 store half, alu_y=0x202, rs2=0x0000BEEF, immediate ack -> bus_we=1, wstrb=4'b1100, wdata=0xBEEFBEEF, rd_wen=0.
REQ-033 load word, pipe_flush in BUS, ack later -> bus_req held until ack, rd_wen=0.
REQ-034 rst asserted in BUS with ack=0 -> next cycle bus_req=0, IDLE; subsequent ack produces no write-back.
REQ-035 MB_MISALIGN_TRAP_EN, load word alu_y=0x06 -> no bus_req, mb_misalign=1 one cycle, rd_wen=0.
